thermal_bit_decoder: RTL and testbench
======================================

Name: thermal_bit_decoder

Overview:
- Receiver stage directly downstream of the ring-oscillator edge counter in the temporal thermal covert channel.
- Samples the free-running oscillator count once per fixed time window and forms the per-window delta.
- Calibrates a baseline delta, then slices each window into one bit: the oscillator slows when hot, so a lower delta means 1.
- Hunts for a sync byte, then emits framed payload bytes to the LED or display stage.

Parameters:
- CNT_W, 20: width of the incoming oscillator edge count.
- WINDOW_LOG2, 24: bit window length is 2^WINDOW_LOG2 clk cycles.
- CAL_LOG2, 3: number of calibration windows is 2^CAL_LOG2.
- MARGIN, 16: delta deficit below baseline needed to decode a 1.
- SYNC_BYTE, 8'hA5: frame preamble.
- FRAME_LEN, 4: payload bytes per frame after sync.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- osc_count  in  CNT_W  free-running oscillator edge count, synchronous to clk
- cal_req  in  1  one-cycle pulse; restarts calibration
- calibrated  out  1  baseline valid
- baseline  out  CNT_W  mean calibration delta
- bit_valid  out  1  one-cycle pulse per decoded bit
- bit_value  out  1  decoded bit
- byte_valid  out  1  one-cycle pulse per payload byte
- byte_data  out  8  payload byte, MSB first on air
- state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset is asynchronous and active-low. All outputs, counters and registers clear to 0. FSM enters PRIME.
- Window timer: WINDOW_LOG2-bit free-running counter. Window end (win_end) is the cycle the timer equals all-ones. Timer restarts at 0 on cal_req.
- At win_end:
  - sample = osc_count
  - delta = (sample - prev) mod 2^CNT_W; wrap-around is handled by truncation
  - prev <= sample
- FSM states are PRIME=0, CAL=1, HUNT=2, DATA=3.
- PRIME: on win_end, latch prev only; no delta is used. Go to CAL. Clear acc and cal_cnt.
- CAL:
  - On each win_end, acc += delta. acc width is CNT_W+CAL_LOG2, so no overflow.
  - After 2^CAL_LOG2 windows: baseline <= acc >> CAL_LOG2, calibrated <= 1, go to HUNT.
- Slicer (HUNT and DATA only, at win_end):
  - bit = 1 iff baseline >= MARGIN and delta <= baseline - MARGIN; else 0.
  - Compute in CNT_W+1 bits; no underflow.
  - bit_valid and bit_value are registered: they pulse the cycle after win_end.
- HUNT:
  - Each bit shifts into an 8-bit shift register at the LSB.
  - When the register equals SYNC_BYTE (including the bit just shifted), go to DATA. Clear bit_cnt and byte_cnt.
- DATA:
  - Shift bits into a data register.
  - On the 8th bit, byte_data <= assembled byte and byte_valid pulses one cycle, aligned with that bit's bit_valid.
  - byte_cnt increments. After FRAME_LEN bytes, go to HUNT with the hunt shift register cleared.
- cal_req (any state): next cycle is PRIME, calibrated <= 0, and partial byte and frame are discarded. baseline holds its old value until recalibrated. cal_req coincident with win_end takes priority; that window's sample is not sliced.
- Only the decoder drives state; there is no backpressure. Consumers must accept byte_valid when it pulses.
- Latency: byte_valid fires 1 cycle after the win_end of the 8th bit.

Decomposition:
- Shared package thermal_pkg holds:
  - FSM state typedef (PRIME/CAL/HUNT/DATA)
  - SYNC_BYTE default
  - CNT_W default
- One sub-module, thermal_window_timer: window counter plus win_end strobe and restart input. The rest lives in the top level.

Test Plan (WINDOW_LOG2=4, CAL_LOG2=3, MARGIN=16):
- Calibration: osc_count advances 100 per window. After 1 prime window and 8 calibration windows: calibrated=1, baseline=100, state_dbg=2.
- Slicing: after calibration, deltas 84, 85, 100, 60 -> bit_value 1, 0, 0, 1 with one bit_valid each; no byte_valid in HUNT.
- Sync and frame: bits of 0xA5 then 0x3C, 0xFF, 0x00, 0x81 -> state_dbg goes to 3 after the sync. Four byte_valid pulses carry those values, then state_dbg returns to 2.
- Wrap-around: prev=0xFFFC0, osc_count=0x00024 at win_end -> delta=100, bit 0.
- cal_req mid-byte: pulse cal_req after 5 DATA bits, coincident with win_end -> no byte_valid, calibrated=0, state_dbg=0. A new calibration with delta 200 gives baseline=200.
- Async reset: assert rst_n low mid-DATA, off the clock edge -> all outputs 0 immediately; after release, state_dbg=0.

Source files
------------

// File: rtl/thermal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thermal_pkg
// Purpose  : Shared types and defaults for the thermal covert-channel
//            receiver (decoder FSM state encoding, preamble, count width).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package thermal_pkg;

   // Decoder FSM states; the encoding is exported on state_dbg.
   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_CAL   = 2'd1,
      ST_HUNT  = 2'd2,
      ST_DATA  = 2'd3
   } state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         CNT_W_DEF     = 20;

endpackage
`default_nettype wire

// File: rtl/thermal_window_timer.sv
`default_nettype none
// ============================================================================
// Module   : thermal_window_timer
// Purpose  : Free-running bit-window timer. Flags the last cycle of each
//            2^WINDOW_LOG2-cycle window and restarts from zero on request.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            restart  - force the timer back to zero on the next edge
//            win_end  - high during the final cycle of a window
// Revision : 1.0 - initial release
// ============================================================================
module thermal_window_timer #(
   parameter int WINDOW_LOG2 = 24
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic win_end
);

   logic [WINDOW_LOG2-1:0] count_q;
   logic [WINDOW_LOG2-1:0] count_d;

   always_comb begin
      count_d = count_q + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
      if (restart) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign win_end = &count_q;

endmodule
`default_nettype wire

// File: rtl/thermal_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : thermal_bit_decoder
// Purpose  : Receiver for the temporal thermal covert channel. Forms a
//            per-window oscillator count delta, calibrates a baseline,
//            slices each window into a bit (slower oscillator = hot = 1),
//            hunts for the sync byte and emits framed payload bytes.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            osc_count  - free-running oscillator edge count (clk domain)
//            cal_req    - one-cycle pulse, restarts calibration
//            calibrated - baseline valid
//            baseline   - mean calibration delta
//            bit_valid  - one-cycle pulse per decoded bit
//            bit_value  - decoded bit
//            byte_valid - one-cycle pulse per payload byte
//            byte_data  - payload byte (MSB first on air)
//            state_dbg  - current FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
module thermal_bit_decoder
   import thermal_pkg::*;
#(
   parameter int         CNT_W       = CNT_W_DEF,
   parameter int         WINDOW_LOG2 = 24,
   parameter int         CAL_LOG2    = 3,
   parameter int         MARGIN      = 16,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         FRAME_LEN   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] osc_count,
   input  logic             cal_req,
   output logic             calibrated,
   output logic [CNT_W-1:0] baseline,
   output logic             bit_valid,
   output logic             bit_value,
   output logic             byte_valid,
   output logic [7:0]       byte_data,
   output logic [1:0]       state_dbg
);

   localparam int ACC_W = CNT_W + CAL_LOG2;
   localparam int BC_W  = $clog2(FRAME_LEN) + 1;
   localparam logic [CAL_LOG2:0] CAL_LAST   = (CAL_LOG2+1)'((1 << CAL_LOG2) - 1);
   localparam logic [BC_W-1:0]   BYTE_LAST  = BC_W'(FRAME_LEN - 1);
   localparam logic [CNT_W:0]    MARGIN_EXT = (CNT_W+1)'(MARGIN);

   state_e            state_q,      state_d;
   logic [CNT_W-1:0]  prev_q,       prev_d;
   logic [ACC_W-1:0]  acc_q,        acc_d;
   logic [CAL_LOG2:0] cal_cnt_q,    cal_cnt_d;
   logic [CNT_W-1:0]  baseline_q,   baseline_d;
   logic              calibrated_q, calibrated_d;
   logic              bit_valid_q,  bit_valid_d;
   logic              bit_value_q,  bit_value_d;
   logic [7:0]        hunt_sr_q,    hunt_sr_d;
   logic [6:0]        data_sr_q,    data_sr_d;
   logic [2:0]        bit_cnt_q,    bit_cnt_d;
   logic [BC_W-1:0]   byte_cnt_q,   byte_cnt_d;
   logic              byte_valid_q, byte_valid_d;
   logic [7:0]        byte_data_q,  byte_data_d;

   logic             win_end;
   logic [CNT_W-1:0] delta;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W:0]   threshold;
   logic             slice_bit;
   logic [7:0]       hunt_shift;
   logic [7:0]       data_shift;

   thermal_window_timer #(
      .WINDOW_LOG2 (WINDOW_LOG2)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (cal_req),
      .win_end (win_end)
   );

   // Modular subtraction absorbs counter wrap-around.
   assign delta   = osc_count - prev_q;
   assign acc_sum = acc_q + {{CAL_LOG2{1'b0}}, delta};

   // One extra bit: threshold MSB set means baseline < MARGIN, which forces 0.
   assign threshold  = {1'b0, baseline_q} - MARGIN_EXT;
   assign slice_bit  = !threshold[CNT_W] && ({1'b0, delta} <= threshold);
   assign hunt_shift = {hunt_sr_q[6:0], slice_bit};
   assign data_shift = {data_sr_q, slice_bit};

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      acc_d        = acc_q;
      cal_cnt_d    = cal_cnt_q;
      baseline_d   = baseline_q;
      calibrated_d = calibrated_q;
      bit_valid_d  = 1'b0;
      bit_value_d  = bit_value_q;
      hunt_sr_d    = hunt_sr_q;
      data_sr_d    = data_sr_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;

      if (cal_req) begin
         // Wins over a coincident window end; baseline is kept until replaced.
         state_d      = ST_PRIME;
         calibrated_d = 1'b0;
         hunt_sr_d    = '0;
         data_sr_d    = '0;
         bit_cnt_d    = '0;
         byte_cnt_d   = '0;
      end else if (win_end) begin
         prev_d = osc_count;
         case (state_q)
            ST_PRIME: begin
               acc_d     = '0;
               cal_cnt_d = '0;
               state_d   = ST_CAL;
            end
            ST_CAL: begin
               acc_d     = acc_sum;
               cal_cnt_d = cal_cnt_q + {{CAL_LOG2{1'b0}}, 1'b1};
               if (cal_cnt_q == CAL_LAST) begin
                  baseline_d   = acc_sum[CAL_LOG2 +: CNT_W];
                  calibrated_d = 1'b1;
                  state_d      = ST_HUNT;
               end
            end
            ST_HUNT: begin
               bit_valid_d = 1'b1;
               bit_value_d = slice_bit;
               hunt_sr_d   = hunt_shift;
               if (hunt_shift == SYNC_BYTE) begin
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  state_d    = ST_DATA;
               end
            end
            ST_DATA: begin
               bit_valid_d = 1'b1;
               bit_value_d = slice_bit;
               data_sr_d   = data_shift[6:0];
               bit_cnt_d   = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_data_d  = data_shift;
                  byte_valid_d = 1'b1;
                  byte_cnt_d   = byte_cnt_q + {{(BC_W-1){1'b0}}, 1'b1};
                  if (byte_cnt_q == BYTE_LAST) begin
                     hunt_sr_d = '0;
                     state_d   = ST_HUNT;
                  end
               end
            end
            default: state_d = ST_PRIME;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_PRIME;
         prev_q       <= '0;
         acc_q        <= '0;
         cal_cnt_q    <= '0;
         baseline_q   <= '0;
         calibrated_q <= 1'b0;
         bit_valid_q  <= 1'b0;
         bit_value_q  <= 1'b0;
         hunt_sr_q    <= '0;
         data_sr_q    <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         acc_q        <= acc_d;
         cal_cnt_q    <= cal_cnt_d;
         baseline_q   <= baseline_d;
         calibrated_q <= calibrated_d;
         bit_valid_q  <= bit_valid_d;
         bit_value_q  <= bit_value_d;
         hunt_sr_q    <= hunt_sr_d;
         data_sr_q    <= data_sr_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
      end
   end

   assign calibrated = calibrated_q;
   assign baseline   = baseline_q;
   assign bit_valid  = bit_valid_q;
   assign bit_value  = bit_value_q;
   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign state_dbg  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_thermal_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_thermal_bit_decoder
// Purpose  : Self-checking bench for thermal_bit_decoder with a 16-cycle
//            window, 8 calibration windows and a margin of 16.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_thermal_bit_decoder;

   localparam int WIN = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] osc_count;
   logic        cal_req;
   logic        calibrated;
   logic [19:0] baseline;
   logic        bit_valid;
   logic        bit_value;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   int bit_pulses  = 0;
   int byte_pulses = 0;

   typedef struct {
      int unsigned delta;
      logic        exp_bit;
      logic        exp_byv;
      logic [7:0]  exp_byte;
      logic [1:0]  exp_state;
   } vec_t;

   vec_t vq[$];

   thermal_bit_decoder #(
      .CNT_W       (20),
      .WINDOW_LOG2 (4),
      .CAL_LOG2    (3),
      .MARGIN      (16),
      .SYNC_BYTE   (8'hA5),
      .FRAME_LEN   (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .osc_count  (osc_count),
      .cal_req    (cal_req),
      .calibrated (calibrated),
      .baseline   (baseline),
      .bit_valid  (bit_valid),
      .bit_value  (bit_value),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bit_valid)  bit_pulses++;
      if (byte_valid) byte_pulses++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Called just after a negedge that follows a window end; returns #1 after
   // the next window-end edge, where the registered outputs are visible.
   task automatic window_to(input logic [19:0] v);
      osc_count = v;
      repeat (WIN) @(posedge clk);
      #1;
   endtask

   task automatic window(input int unsigned d);
      window_to(osc_count + 20'(d));
      @(negedge clk);
   endtask

   task automatic push(input int unsigned d, input logic b, input logic byv,
                       input logic [7:0] by, input logic [1:0] st);
      vec_t v;
      v.delta = d; v.exp_bit = b; v.exp_byv = byv; v.exp_byte = by; v.exp_state = st;
      vq.push_back(v);
   endtask

   task automatic push_byte(input logic [7:0] b, input int unsigned d1, input int unsigned d0,
                            input logic [1:0] st_mid, input logic [1:0] st_last,
                            input logic is_data);
      for (int i = 7; i >= 0; i--)
         push(b[i] ? d1 : d0, b[i], is_data && (i == 0), b, (i == 0) ? st_last : st_mid);
   endtask

   task automatic run_vectors();
      for (int k = 0; k < vq.size(); k++) begin
         osc_count = osc_count + 20'(vq[k].delta);
         repeat (WIN) @(posedge clk);
         #1;
         chk($sformatf("v%0d_bit_valid", k), bit_valid, 1);
         chk($sformatf("v%0d_bit_value", k), bit_value, vq[k].exp_bit);
         chk($sformatf("v%0d_byte_valid", k), byte_valid, vq[k].exp_byv);
         if (vq[k].exp_byv)
            chk($sformatf("v%0d_byte_data", k), byte_data, vq[k].exp_byte);
         chk($sformatf("v%0d_state", k), state_dbg, vq[k].exp_state);
         @(negedge clk);
      end
      #1;
   endtask

   initial begin
      int b0, y0;

      // ---------------- reset state ----------------
      rst_n = 1'b0; osc_count = '0; cal_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_calibrated", calibrated, 0);
      chk("rst_baseline",   baseline,   0);
      chk("rst_bit_valid",  bit_valid,  0);
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_byte_data",  byte_data,  0);
      chk("rst_state",      state_dbg,  0);
      rst_n = 1'b1;

      // ---------------- calibration: +100 per window ----------------
      b0 = bit_pulses;
      window(100);
      chk("prime_to_cal", state_dbg, 1);
      for (int i = 0; i < 8; i++) begin
         window(100);
         if (i == 6) chk("cal_not_done_7", calibrated, 0);
      end
      chk("cal_calibrated", calibrated, 1);
      chk("cal_baseline",   baseline,   100);
      chk("cal_state_hunt", state_dbg,  2);
      chk("cal_no_bits",    bit_pulses - b0, 0);

      // ---------------- slicing + sync + frame ----------------
      vq.delete();
      push(84,  1'b1, 1'b0, 8'h00, 2'd2);
      push(85,  1'b0, 1'b0, 8'h00, 2'd2);
      push(100, 1'b0, 1'b0, 8'h00, 2'd2);
      push(60,  1'b1, 1'b0, 8'h00, 2'd2);
      push_byte(8'hA5, 60, 100, 2'd2, 2'd3, 1'b0);
      push_byte(8'h3C, 60, 100, 2'd3, 2'd3, 1'b1);
      push_byte(8'hFF, 60, 100, 2'd3, 2'd3, 1'b1);
      push_byte(8'h00, 60, 100, 2'd3, 2'd3, 1'b1);
      push_byte(8'h81, 60, 100, 2'd3, 2'd2, 1'b1);
      b0 = bit_pulses; y0 = byte_pulses;
      run_vectors();
      chk("frame_bit_pulses",  bit_pulses - b0,  44);
      chk("frame_byte_pulses", byte_pulses - y0, 4);

      // ---------------- wrap-around of the oscillator count ----------------
      window_to(20'hFFFC0); @(negedge clk);
      window_to(20'h00024);
      chk("wrap0_valid", bit_valid, 1);
      chk("wrap0_value", bit_value, 0);
      @(negedge clk);
      window_to(20'hFFFF0); @(negedge clk);
      window_to(20'h0002C);
      chk("wrap1_valid", bit_valid, 1);
      chk("wrap1_value", bit_value, 1);
      @(negedge clk);

      // ---------------- cal_req mid-byte, coincident with win_end ----------------
      vq.delete();
      push_byte(8'hA5, 60, 100, 2'd2, 2'd3, 1'b0);
      push(100, 1'b0, 1'b0, 8'h00, 2'd3);
      push(100, 1'b0, 1'b0, 8'h00, 2'd3);
      push(60,  1'b1, 1'b0, 8'h00, 2'd3);
      push(60,  1'b1, 1'b0, 8'h00, 2'd3);
      push(60,  1'b1, 1'b0, 8'h00, 2'd3);
      y0 = byte_pulses;
      run_vectors();
      osc_count = osc_count + 20'd60;
      repeat (WIN - 1) @(posedge clk);
      @(negedge clk);
      cal_req = 1'b1;
      @(posedge clk);
      #1;
      cal_req = 1'b0;
      chk("calreq_bit_valid",  bit_valid,  0);
      chk("calreq_byte_valid", byte_valid, 0);
      chk("calreq_calibrated", calibrated, 0);
      chk("calreq_state",      state_dbg,  0);
      chk("calreq_baseline_hold", baseline, 100);
      @(negedge clk);
      #1;
      chk("calreq_no_byte", byte_pulses - y0, 0);

      // ---------------- recalibration at +200 per window ----------------
      window(200);
      chk("recal_prime_to_cal", state_dbg, 1);
      for (int i = 0; i < 8; i++) window(200);
      chk("recal_calibrated", calibrated, 1);
      chk("recal_baseline",   baseline,   200);
      chk("recal_state",      state_dbg,  2);

      // ---------------- threshold edges, new frame, async reset mid-DATA ----------------
      vq.delete();
      push(184, 1'b1, 1'b0, 8'h00, 2'd2);
      push(185, 1'b0, 1'b0, 8'h00, 2'd2);
      push_byte(8'hA5, 150, 200, 2'd2, 2'd3, 1'b0);
      push_byte(8'h5A, 150, 200, 2'd3, 2'd3, 1'b1);
      push(150, 1'b1, 1'b0, 8'h00, 2'd3);
      push(200, 1'b0, 1'b0, 8'h00, 2'd3);
      push(150, 1'b1, 1'b0, 8'h00, 2'd3);
      run_vectors();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_calibrated", calibrated, 0);
      chk("arst_baseline",   baseline,   0);
      chk("arst_bit_value",  bit_value,  0);
      chk("arst_byte_valid", byte_valid, 0);
      chk("arst_byte_data",  byte_data,  0);
      chk("arst_state",      state_dbg,  0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_release_state", state_dbg, 0);
      window(100);
      chk("arst_prime_to_cal", state_dbg, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
